// File: rtl/sram_frame_writer_pkg.sv
// Shared constants for the SRAM frame writer: address/pixel widths and FSM encodings.
package sram_frame_writer_pkg;

  localparam int ADDR_W = 18;
  localparam int PIX_W  = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

endpackage

// File: rtl/sram_frame_writer_pixel_fifo.sv
// Show-ahead pixel FIFO with flush; head is valid whenever empty is low, 1-cycle push-to-head.
// Pushes into a full buffer land only if a pop or flush happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;
  logic [PW-1:0]    wr_idx;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head    = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push && (!full || pop || flush);
  assign do_pop  = pop && !empty && !flush;
  // A flush restarts at slot 0 so a same-cycle push becomes the new head.
  assign wr_idx  = flush ? '0 : wr_ptr_q[PW-1:0];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) mem_d[wr_idx] = din;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = do_push ? (PW+1)'(1) : '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/sram_frame_writer.sv
// Streams captured RGB222 pixels into an async SRAM, one 3-cycle write (setup/strobe/hold) per pixel.
// Pixels arriving while the buffer is full are dropped and flagged; v_sync restarts the frame at address 0.
module sram_frame_writer
  import sram_frame_writer_pkg::*;
#(
  parameter int ADDR_W     = sram_frame_writer_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              rec,
  input  logic              rpi_DEN,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              v_sync_in,
  output logic [ADDR_W-1:0] addr,
  output logic [7:0]        io_out,
  output logic              io_oe,
  output logic              we,
  output logic [1:0]        frame_count,
  output logic              overflow,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PIX_W-1:0]  data_q, data_d;
  logic [1:0]        frame_q, frame_d;
  logic              overflow_q, overflow_d;
  logic              pending_q, pending_d;
  logic              vs_q;

  logic              vs_edge;
  logic              push_req;
  logic              pop;
  logic              start;
  logic              zero_addr;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_head;

  assign vs_edge   = v_sync_in && !vs_q;
  assign push_req  = rpi_DEN && !rec;
  // Hold off a new write in the flush cycle so the old frame's head is never fetched.
  assign start     = !fifo_empty && !rec && !vs_edge;
  assign zero_addr = pending_q || vs_edge;
  assign drop      = push_req && fifo_full && !pop && !vs_edge;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk_in (clk_in),
    .reset  (reset),
    .push   (push_req),
    .pop    (pop),
    .flush  (vs_edge),
    .din    (pix_data),
    .head   (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    pop        = 1'b0;
    pending_d  = zero_addr;
    frame_d    = vs_edge ? frame_q + 2'd1 : frame_q;
    overflow_d = vs_edge ? 1'b0 : (overflow_q || drop);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          pop     = 1'b1;
          data_d  = fifo_head;
          if (pending_q) begin
            addr_d    = '0;
            pending_d = 1'b0;
          end
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        // The finishing write keeps its address; a frame restart only retargets the next one.
        addr_d    = zero_addr ? '0 : addr_q + ADDR_W'(1);
        pending_d = 1'b0;
        if (start) begin
          state_d = ST_SETUP;
          pop     = 1'b1;
          data_d  = fifo_head;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      frame_q    <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      frame_q    <= frame_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
      vs_q       <= v_sync_in;
    end
  end

  assign addr        = addr_q;
  assign io_out      = {2'b00, data_q};
  assign io_oe       = (state_q != ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign we          = (state_q != ST_STROBE);
  assign frame_count = frame_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Directed bench for sram_frame_writer; a narrow-address twin instance exercises address wrap.
module tb_sram_frame_writer;

  logic        clk_in = 1'b0;
  logic        reset, rec, rpi_DEN, v_sync_in;
  logic [5:0]  pix_data;
  logic [17:0] addr;
  logic [7:0]  io_out;
  logic        io_oe, we, overflow, busy;
  logic [1:0]  frame_count;
  logic [2:0]  n_addr;
  logic [7:0]  n_io_out;
  logic        n_io_oe, n_we, n_overflow, n_busy;
  logic [1:0]  n_frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] cap_addr[$];
  logic [7:0]  cap_dat[$];
  logic [2:0]  ncap_addr[$];

  always #5 clk_in = ~clk_in;

  sram_frame_writer dut (
    .clk_in(clk_in), .reset(reset), .rec(rec), .rpi_DEN(rpi_DEN), .pix_data(pix_data),
    .v_sync_in(v_sync_in), .addr(addr), .io_out(io_out), .io_oe(io_oe), .we(we),
    .frame_count(frame_count), .overflow(overflow), .busy(busy)
  );

  sram_frame_writer #(.ADDR_W(3), .FIFO_DEPTH(4)) dut_narrow (
    .clk_in(clk_in), .reset(reset), .rec(rec), .rpi_DEN(rpi_DEN), .pix_data(pix_data),
    .v_sync_in(v_sync_in), .addr(n_addr), .io_out(n_io_out), .io_oe(n_io_oe), .we(n_we),
    .frame_count(n_frame_count), .overflow(n_overflow), .busy(n_busy)
  );

  // Record every SRAM write strobe (sampled mid-cycle).
  always @(negedge clk_in) begin
    if (reset && !we) begin
      cap_addr.push_back(addr);
      cap_dat.push_back(io_out);
    end
    if (reset && !n_we) ncap_addr.push_back(n_addr);
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_caps();
    cap_addr.delete();
    cap_dat.delete();
    ncap_addr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; rec = 1'b0; rpi_DEN = 1'b0; v_sync_in = 1'b0; pix_data = '0;
    #2;
    n_cmp++; if (we !== 1'b1)       begin n_bad++; $display("FAIL reset_we: got %b want 1", we); end
    n_cmp++; if (io_oe !== 1'b0)    begin n_bad++; $display("FAIL reset_io_oe: got %b want 0", io_oe); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (addr !== 18'd0)    begin n_bad++; $display("FAIL reset_addr: got %0h want 0", addr); end
    n_cmp++; if (io_out !== 8'h00)  begin n_bad++; $display("FAIL reset_io_out: got %0h want 0", io_out); end
    n_cmp++; if (frame_count !== 2'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    idle(2);
    reset = 1'b1;
    idle(3);
    n_cmp++; if (busy !== 1'b0 || we !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle: busy %b we %b want 0 1", busy, we); end
  endtask

  task automatic test_single_write();
    logic [6:0] busy_v, we_v, oe_v;
    logic [7:0] setup_dat;
    busy_v = '0; we_v = '0; oe_v = '0; setup_dat = '0;
    step();
    clear_caps();
    rpi_DEN = 1'b1; pix_data = 6'h2A;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_in);
      busy_v = {busy_v[5:0], busy};
      we_v   = {we_v[5:0], we};
      oe_v   = {oe_v[5:0], io_oe};
      if (i == 2) setup_dat = io_out;
      @(posedge clk_in); #1;
      rpi_DEN = 1'b0;
    end
    n_cmp++; if (busy_v !== 7'b0011100) begin n_bad++; $display("FAIL single_busy_seq: got %b want 0011100", busy_v); end
    n_cmp++; if (we_v !== 7'b1110111)   begin n_bad++; $display("FAIL single_we_seq: got %b want 1110111", we_v); end
    n_cmp++; if (oe_v !== 7'b0011100)   begin n_bad++; $display("FAIL single_oe_seq: got %b want 0011100", oe_v); end
    n_cmp++; if (setup_dat !== 8'h2A)   begin n_bad++; $display("FAIL single_setup_data: got %0h want 2a", setup_dat); end
    n_cmp++; if (cap_addr.size() != 1 || cap_addr[0] !== 18'd0 || cap_dat[0] !== 8'h2A)
      begin n_bad++; $display("FAIL single_write: writes %0d addr %0h data %0h want 1 0 2a", cap_addr.size(), cap_addr[0], cap_dat[0]); end
    n_cmp++; if (addr !== 18'd1) begin n_bad++; $display("FAIL single_addr_after: got %0h want 1", addr); end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [7];
    exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h04;
    exp_d[4] = 8'h05; exp_d[5] = 8'h06; exp_d[6] = 8'h08;
    step();
    clear_caps();
    for (int i = 1; i <= 8; i++) begin
      rpi_DEN = 1'b1; pix_data = 6'(i);
      step();
    end
    rpi_DEN = 1'b0;
    idle(40);
    n_cmp++; if (cap_addr.size() != 7) begin n_bad++; $display("FAIL ovf_write_count: got %0d want 7", cap_addr.size()); end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (cap_addr[i] !== 18'(i + 1) || cap_dat[i] !== exp_d[i])
        begin n_bad++; $display("FAIL ovf_write%0d: addr %0h data %0h want %0h %0h", i, cap_addr[i], cap_dat[i], i + 1, exp_d[i]); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (addr !== 18'd8)   begin n_bad++; $display("FAIL ovf_addr_after: got %0h want 8", addr); end
  endtask

  task automatic test_vsync();
    step();
    rpi_DEN = 1'b1; pix_data = 6'h3C;
    step();
    rpi_DEN = 1'b0;
    idle(8);
    clear_caps();
    n_cmp++; if (overflow !== 1'b1 || addr !== 18'd9) begin n_bad++; $display("FAIL vs_precond: overflow %b addr %0h want 1 9", overflow, addr); end
    rpi_DEN = 1'b1; pix_data = 6'h15; step();
    pix_data = 6'h16; step();
    pix_data = 6'h17; step();
    pix_data = 6'h18; v_sync_in = 1'b1;
    @(negedge clk_in);
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL vs_in_strobe: we %b want 0", we); end
    step();
    rpi_DEN = 1'b0;
    idle(20);
    v_sync_in = 1'b0;
    n_cmp++; if (cap_addr.size() != 2) begin n_bad++; $display("FAIL vs_write_count: got %0d want 2", cap_addr.size()); end
    n_cmp++; if (cap_addr[0] !== 18'd9 || cap_dat[0] !== 8'h15) begin n_bad++; $display("FAIL vs_old_write: addr %0h data %0h want 9 15", cap_addr[0], cap_dat[0]); end
    n_cmp++; if (cap_addr[1] !== 18'd0 || cap_dat[1] !== 8'h18) begin n_bad++; $display("FAIL vs_new_write: addr %0h data %0h want 0 18", cap_addr[1], cap_dat[1]); end
    n_cmp++; if (frame_count !== 2'd1) begin n_bad++; $display("FAIL vs_frame_count: got %0d want 1", frame_count); end
    n_cmp++; if (overflow !== 1'b0)    begin n_bad++; $display("FAIL vs_overflow: got %b want 0", overflow); end
    n_cmp++; if (addr !== 18'd1)       begin n_bad++; $display("FAIL vs_addr_after: got %0h want 1", addr); end
  endtask

  task automatic test_rec_mid_write();
    step();
    clear_caps();
    rpi_DEN = 1'b1; pix_data = 6'h21; step();
    pix_data = 6'h22; step();
    pix_data = 6'h23; step();
    rpi_DEN = 1'b0;
    idle(2);
    rec = 1'b1; rpi_DEN = 1'b1; pix_data = 6'h3F;
    idle(12);
    n_cmp++; if (cap_addr.size() != 2) begin n_bad++; $display("FAIL rec_write_count: got %0d want 2", cap_addr.size()); end
    n_cmp++; if (cap_addr[1] !== 18'd2 || cap_dat[1] !== 8'h22) begin n_bad++; $display("FAIL rec_last_write: addr %0h data %0h want 2 22", cap_addr[1], cap_dat[1]); end
    n_cmp++; if (we !== 1'b1 || io_oe !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rec_idle: we %b oe %b busy %b want 1 0 0", we, io_oe, busy); end
    n_cmp++; if (addr !== 18'd3) begin n_bad++; $display("FAIL rec_addr: got %0h want 3", addr); end
    rec = 1'b0; rpi_DEN = 1'b0;
    idle(10);
    n_cmp++; if (cap_addr.size() != 3 || cap_addr[2] !== 18'd3 || cap_dat[2] !== 8'h23)
      begin n_bad++; $display("FAIL rec_resume: writes %0d addr %0h data %0h want 3 3 23", cap_addr.size(), cap_addr[2], cap_dat[2]); end
  endtask

  task automatic test_reset_mid_write();
    step();
    rpi_DEN = 1'b1; pix_data = 6'h0F; step();
    pix_data = 6'h0E; step();
    pix_data = 6'h0D; step();
    rpi_DEN = 1'b0;
    @(negedge clk_in);
    n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rst_precond_strobe: we %b want 0", we); end
    #1 reset = 1'b0;
    #1;
    clear_caps();
    n_cmp++; if (we !== 1'b1 || io_oe !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_async_ctrl: we %b oe %b busy %b want 1 0 0", we, io_oe, busy); end
    n_cmp++; if (addr !== 18'd0 || io_out !== 8'h00) begin n_bad++; $display("FAIL rst_async_bus: addr %0h io_out %0h want 0 0", addr, io_out); end
    n_cmp++; if (frame_count !== 2'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL rst_async_status: fc %0d ovf %b want 0 0", frame_count, overflow); end
    @(posedge clk_in); #1;
    reset = 1'b1;
    idle(10);
    n_cmp++; if (cap_addr.size() != 0) begin n_bad++; $display("FAIL rst_fifo_flushed: writes %0d want 0", cap_addr.size()); end
  endtask

  task automatic test_addr_wrap();
    step();
    clear_caps();
    for (int k = 0; k < 9; k++) begin
      rpi_DEN = 1'b1; pix_data = 6'(k + 1);
      step();
      rpi_DEN = 1'b0;
      idle(5);
    end
    idle(6);
    n_cmp++; if (ncap_addr.size() != 9) begin n_bad++; $display("FAIL wrap_write_count: got %0d want 9", ncap_addr.size()); end
    n_cmp++; if (ncap_addr[7] !== 3'd7 || ncap_addr[8] !== 3'd0) begin n_bad++; $display("FAIL wrap_addrs: got %0h %0h want 7 0", ncap_addr[7], ncap_addr[8]); end
    n_cmp++; if (n_addr !== 3'd1) begin n_bad++; $display("FAIL wrap_addr_after: got %0h want 1", n_addr); end
    n_cmp++; if (n_frame_count !== 2'd0 || n_overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_side_effect: fc %0d ovf %b want 0 0", n_frame_count, n_overflow); end
    n_cmp++; if (cap_addr.size() != 9 || cap_addr[8] !== 18'd8) begin n_bad++; $display("FAIL wide_no_wrap: writes %0d last %0h want 9 8", cap_addr.size(), cap_addr[8]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_overflow();
    test_vsync();
    test_rec_mid_write();
    test_reset_mid_write();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
